// File: rtl/mdu_pkg.sv
// Shared op codes, FSM state type and helpers for the iterative multiply/divide unit.
package mdu_pkg;

    localparam logic [2:0] MDU_MULT  = 3'b000;
    localparam logic [2:0] MDU_MULTU = 3'b001;
    localparam logic [2:0] MDU_DIV   = 3'b010;
    localparam logic [2:0] MDU_DIVU  = 3'b011;
    localparam logic [2:0] MDU_MTHI  = 3'b100;
    localparam logic [2:0] MDU_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } mdu_state_e;

    // Ops whose operands are two's-complement and need magnitude conversion
    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division iteration: trial-subtract the divisor from the shifted remainder.
module mdu_div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);

    logic [WIDTH:0] diff;

    // rem_i < 2*divisor, so whichever branch is kept fits back into WIDTH bits
    always_comb begin
        diff  = rem_i - {1'b0, divisor_i};
        q_o   = (rem_i >= {1'b0, divisor_i});
        rem_o = q_o ? diff[WIDTH-1:0] : rem_i[WIDTH-1:0];
    end

endmodule

// File: rtl/mdu.sv
// Iterative multiply/divide unit with HI/LO registers: shift-add multiply and restoring
// divide, one bit per cycle, with start/busy/done handshake, cancel, and MTHI/MTLO.
module mdu
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned ACC_W = 2 * WIDTH;

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] a_raw_q, a_raw_d;
    logic             is_div_q, is_div_d;
    logic             neg_lo_q, neg_lo_d;
    logic             neg_hi_q, neg_hi_d;
    logic             div0_q, div0_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             sa, sb;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   mul_sum;
    logic [ACC_W-1:0] mul_next, div_next, step_acc, prod;
    logic [WIDTH-1:0] quo, rem;
    logic [WIDTH-1:0] div_rem;
    logic             div_q;

    // acc holds {remainder, dividend->quotient} while dividing
    mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_i     ({acc_q[ACC_W-1:WIDTH], acc_q[WIDTH-1]}),
        .divisor_i (opnd_q),
        .rem_o     (div_rem),
        .q_o       (div_q)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        a_raw_d  = a_raw_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        div0_d   = div0_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;

        sa    = op_is_signed(op) & a[WIDTH-1];
        sb    = op_is_signed(op) & b[WIDTH-1];
        mag_a = sa ? -a : a;
        mag_b = sb ? -b : b;

        // Multiply: multiplier sits in acc low half and shifts out as the product shifts in
        mul_sum  = {1'b0, acc_q[ACC_W-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : WIDTH'(0))};
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};
        div_next = {div_rem, acc_q[WIDTH-2:0], div_q};
        step_acc = is_div_q ? div_next : mul_next;

        // Sign fix-up applied to the final iteration's result on the way into HI/LO
        prod = neg_lo_q ? -step_acc : step_acc;
        quo  = neg_lo_q ? -step_acc[WIDTH-1:0] : step_acc[WIDTH-1:0];
        rem  = neg_hi_q ? -step_acc[ACC_W-1:WIDTH] : step_acc[ACC_W-1:WIDTH];

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    unique case (op)
                        MDU_MULT, MDU_MULTU: begin
                            state_d  = CALC;
                            busy_d   = 1'b1;
                            cnt_d    = CNT_W'(0);
                            is_div_d = 1'b0;
                            opnd_d   = mag_a;
                            acc_d    = {WIDTH'(0), mag_b};
                            neg_lo_d = sa ^ sb;
                            neg_hi_d = 1'b0;
                            div0_d   = 1'b0;
                        end
                        MDU_DIV, MDU_DIVU: begin
                            state_d  = CALC;
                            busy_d   = 1'b1;
                            cnt_d    = CNT_W'(0);
                            is_div_d = 1'b1;
                            opnd_d   = mag_b;
                            acc_d    = {WIDTH'(0), mag_a};
                            neg_lo_d = sa ^ sb;
                            neg_hi_d = sa;
                            div0_d   = (b == WIDTH'(0));
                            a_raw_d  = a;
                        end
                        MDU_MTHI: hi_d = a;
                        MDU_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            CALC: begin
                if (cancel) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = CNT_W'(0);
                end else begin
                    acc_d = step_acc;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        if (!is_div_q) begin
                            {hi_d, lo_d} = prod;
                        end else if (div0_q) begin
                            hi_d = a_raw_q;
                            lo_d = '1;
                        end else begin
                            hi_d = rem;
                            lo_d = quo;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                cnt_d   = CNT_W'(0);
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            a_raw_q  <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            div0_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            a_raw_q  <= a_raw_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            div0_q   <= div0_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Directed, table-driven bench for mdu (WIDTH=32) plus hand-written handshake sequences.
module tb_mdu;
    import mdu_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[12];

    mdu #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .cancel (cancel),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, got, exp);
        end
    endtask

    // Issue an op, then report the cycle (1-based after the start edge) at which done is seen
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int lat, output int busy_gaps);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start     = 1'b0;
        lat       = 0;
        busy_gaps = 0;
        for (int k = 1; k <= 60; k++) begin
            if (k > 1) @(negedge clk);
            if (!busy) busy_gaps++;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        int  lat;
        int  gaps;
        int  seen;

        vecs[0]  = '{MDU_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[1]  = '{MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[2]  = '{MDU_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{MDU_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003};
        vecs[4]  = '{MDU_DIV,   32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF};
        vecs[5]  = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[6]  = '{MDU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[7]  = '{MDU_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[8]  = '{MDU_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
        vecs[9]  = '{MDU_MULTU, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000};
        vecs[10] = '{MDU_DIVU,  32'h00000003, 32'h00000000, 32'h00000003, 32'hFFFFFFFF};
        vecs[11] = '{MDU_MULT,  32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFB};

        rst    = 1'b1;
        start  = 1'b0;
        op     = 3'b000;
        a      = '0;
        b      = '0;
        cancel = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, gaps);
            check($sformatf("vec%0d latency", i), 32'(lat), 32'd33);
            check($sformatf("vec%0d busy gaps", i), 32'(gaps), 32'd0);
            check($sformatf("vec%0d hi", i), hi, vecs[i].hi);
            check($sformatf("vec%0d lo", i), lo, vecs[i].lo);
            @(negedge clk);
            check($sformatf("vec%0d done pulse", i), 32'(done), 32'd0);
            check($sformatf("vec%0d busy after", i), 32'(busy), 32'd0);
        end

        // Clear HI/LO with MTHI/MTLO
        @(negedge clk); start = 1'b1; op = MDU_MTHI; a = 32'h0;
        @(negedge clk); op = MDU_MTLO;
        @(negedge clk); start = 1'b0;
        check("clear hi", hi, 32'h0);
        check("clear lo", lo, 32'h0);

        // Cancel mid-calculation
        @(negedge clk); start = 1'b1; op = MDU_MULTU; a = 32'd3; b = 32'd4;
        @(negedge clk); start = 1'b0;
        seen = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) @(negedge clk);
            if (done) seen++;
            if (k == 10) begin
                check("cancel busy before", 32'(busy), 32'd1);
                cancel = 1'b1;
            end
            if (k == 11) begin
                cancel = 1'b0;
                check("cancel busy drop", 32'(busy), 32'd0);
            end
        end
        check("cancel no done", 32'(seen), 32'd0);
        check("cancel hi", hi, 32'h0);
        check("cancel lo", lo, 32'h0);

        // Start and MTHI while busy are ignored
        @(negedge clk); start = 1'b1; op = MDU_MULTU; a = 32'd3; b = 32'd4;
        @(negedge clk); start = 1'b0;
        lat = 0;
        for (int k = 1; k <= 60; k++) begin
            if (k > 1) @(negedge clk);
            if (k == 5) begin start = 1'b1; op = MDU_DIVU; a = 32'd100; b = 32'd3; end
            if (k == 6) start = 1'b0;
            if (k == 8) begin start = 1'b1; op = MDU_MTHI; a = 32'hDEADBEEF; end
            if (k == 9) begin
                start = 1'b0;
                check("mthi busy hi", hi, 32'h0);
            end
            if (done) begin
                lat = k;
                break;
            end
        end
        check("ignored start latency", 32'(lat), 32'd33);
        check("ignored start hi", hi, 32'h0);
        check("ignored start lo", lo, 32'd12);
        @(negedge clk);
        check("ignored start idle", 32'(busy), 32'd0);

        // MTLO in idle
        @(negedge clk); start = 1'b1; op = MDU_MTLO; a = 32'h12345678;
        @(negedge clk); start = 1'b0;
        check("mtlo lo", lo, 32'h12345678);
        check("mtlo hi", hi, 32'h0);
        check("mtlo done", 32'(done), 32'd0);
        check("mtlo busy", 32'(busy), 32'd0);

        // Undefined op code and cancel in idle have no effect
        @(negedge clk); start = 1'b1; op = 3'b110; a = 32'hFFFF0000;
        @(negedge clk); op = 3'b111;
        @(negedge clk); start = 1'b0; cancel = 1'b1;
        @(negedge clk); cancel = 1'b0;
        check("badop busy", 32'(busy), 32'd0);
        check("badop hi", hi, 32'h0);
        check("badop lo", lo, 32'h12345678);

        // Asynchronous reset mid-calculation
        @(negedge clk); start = 1'b1; op = MDU_MTHI; a = 32'hAAAA5555;
        @(negedge clk); op = MDU_MULTU; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
        @(negedge clk); start = 1'b0;
        check("prereset hi", hi, 32'hAAAA5555);
        repeat (9) @(negedge clk);
        check("prereset busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async rst busy", 32'(busy), 32'd0);
        check("async rst done", 32'(done), 32'd0);
        check("async rst hi", hi, 32'h0);
        check("async rst lo", lo, 32'h0);
        #1 rst = 1'b0;
        run_op(MDU_DIVU, 32'd7, 32'd2, lat, gaps);
        check("post rst latency", 32'(lat), 32'd33);
        check("post rst hi", hi, 32'd1);
        check("post rst lo", lo, 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
